alu_mul_sequencer: RTL and testbench
====================================

# alu_mul_sequencer

Multi-cycle sequencer that computes the low 64 bits of an unsigned 64×64 product (LEGv8 MUL) by driving the existing combinational 64-bit ALU with a shift-and-add schedule. It sits beside the EX stage: the pipeline issues a start pulse with both operands, stalls on `busy`, and captures `result` on the `done` pulse. The ALU is instantiated inside the block, so the main EX ALU is not shared.

## Interface
- `DATA_W`, default 64: operand and result width. Fixed at 64 to match the ALU.
- `CNT_W`, default 6: iteration counter width, covering 0..63.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request pulse. Sampled only in IDLE or DONE.
- `flush` in 1: synchronous abort from a pipeline flush.
- `op_a` in 64: multiplicand. Captured when `start` is accepted.
- `op_b` in 64: multiplier. Captured when `start` is accepted.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse when the result is valid.
- `result` out 64: low 64 bits of op_a×op_b. Held from `done` until the next accepted start.
- `zero` out 1: registered; equals (`result` == 0). Valid with `result`.

## Operation
- Internal registers:
  - `mcand` (64): shifts left each iteration.
  - `mplier` (64): shifts right each iteration.
  - `prod` (64): the accumulator.
  - `cnt` (CNT_W): iteration counter.
  - `state`.
- ALU hookup:
  - input_1 = `mcand`.
  - input_2 = `prod`.
  - ALUCnt = ADD (0010) when `mplier[0]` = 1, otherwise PASS (0111, passes input_2).
- States:
  - IDLE: on `start`, load mcand=op_a, mplier=op_b, prod=0, cnt=0, then go to RUN.
  - RUN: each cycle do prod←ALU_result, mcand←mcand<<1, mplier←mplier>>1, cnt←cnt+1. Go to DONE when the shifted mplier is 0 or cnt=63.
  - DONE: `done`=1 for one cycle, latch result/zero from prod. A `start` here is accepted and goes to RUN (back-to-back issue). Otherwise go to IDLE.
- `flush` in RUN or DONE: go to IDLE next cycle with no `done` pulse. `result` and `zero` keep their previous values. `flush` has priority over `start`.
- `start` in RUN is ignored. It is neither queued nor does it corrupt operands.
- Overflow bits above bit 63 are discarded. ADD wraps modulo 2^64.
- Reset (any state, including mid-RUN): state=IDLE, busy=0, done=0, result=0, zero=1, all internal registers 0.

## Timing
- `start` accepted at edge T. `busy`=1 from T+1.
- Iteration count N = max(1, msb_index(op_b)+1), range 1..64.
- RUN occupies cycles T+1..T+N. `done` and valid `result` appear at T+N+1. `busy` falls at T+N+1.
- Best case (op_b ∈ {0,1}): `done` at T+2. Worst case (op_b[63]=1): `done` at T+65.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared package `alu_pkg`:
  - ALUCnt constants: ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_PASS=0111.
  - 64-bit width constant.
  - Sequencer state encoding IDLE/RUN/DONE.
- One sub-module: the existing `ALU`, instantiated once.
- Next-state logic and the datapath registers stay in this module.

## Test plan
- op_a=6, op_b=7, start at T → busy T+1..T+3; done at T+4; result=42, zero=0.
- op_a=123, op_b=0 → done at T+2; result=0, zero=1.
- op_a=0xFFFF_FFFF_FFFF_FFFF, op_b=1 → done at T+2; result=0xFFFF_FFFF_FFFF_FFFF.
- op_a=3, op_b=0x8000_0000_0000_0000 → done at T+65; result=0x8000_0000_0000_0000 (wrap). Also check a start pulse at T+10 is ignored.
- op_a=5, op_b=0xFF, flush at T+3 → no done pulse; busy=0 at T+4; result keeps its prior value. Then start 2×9 → result=18.
- Assert rst_n=0 mid-RUN (asynchronously, between edges) → busy/done/result drop immediately to 0/0/0 and zero=1. After release, 4×4 → result=16, done at T+4.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control encodings, datapath width and MUL sequencer states.
package alu_pkg;

  localparam int ALU_W = 64;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_mul_sequencer_alu.sv
// Combinational 64-bit LEGv8 ALU.
// PASS forwards input_2 unchanged.
module ALU
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] input_1,
  input  logic [ALU_W-1:0] input_2,
  input  logic [3:0]       alu_cnt,
  output logic [ALU_W-1:0] alu_result
);

  always_comb begin
    alu_result = '0;
    case (alu_cnt)
      ALU_AND:  alu_result = input_1 & input_2;
      ALU_OR:   alu_result = input_1 | input_2;
      ALU_ADD:  alu_result = input_1 + input_2;
      ALU_SUB:  alu_result = input_1 - input_2;
      ALU_PASS: alu_result = input_2;
      default:  alu_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add MUL sequencer driving a private ALU.
// Yields the low DATA_W bits of op_a*op_b.
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_W,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              flush,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  seq_state_e        state;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] prod;
  logic [CNT_W-1:0]  cnt;

  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] mplier_nx;
  logic [3:0]        alu_op;
  logic              last;
  logic              accept;

  assign alu_op    = mplier[0] ? ALU_ADD : ALU_PASS;
  assign mplier_nx = mplier >> 1;
  assign last      = (mplier_nx == '0) ||
                     (cnt == CNT_W'(DATA_W - 1));
  assign accept    = start && !flush &&
                     (state == S_IDLE || state == S_DONE);

  ALU u_alu (
    .input_1    (mcand),
    .input_2    (prod),
    .alu_cnt    (alu_op),
    .alu_result (alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b1;
    end else begin
      done <= 1'b0;
      if (accept) begin
        state  <= S_RUN;
        mcand  <= op_a;
        mplier <= op_b;
        prod   <= '0;
        cnt    <= '0;
        busy   <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: ;
          S_RUN: begin
            if (flush) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              prod   <= alu_y;
              mcand  <= mcand << 1;
              mplier <= mplier_nx;
              cnt    <= cnt + 1'b1;
              // result is latched here so it is valid with done
              if (last) begin
                state  <= S_DONE;
                busy   <= 1'b0;
                done   <= 1'b1;
                result <= alu_y;
                zero   <= (alu_y == '0);
              end
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Randomized bench for alu_mul_sequencer.
// Expected products and latencies come from plain arithmetic.
module tb_alu_mul_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        zero;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_res;

  alu_mul_sequencer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int iters(input logic [63:0] b);
    int n = 1;
    for (int i = 0; i < 64; i++)
      if (b[i]) n = i + 1;
    return n;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Issues a start now; returns in the cycle where done must be high.
  task automatic run_op(input logic [63:0] a,
                        input logic [63:0] b,
                        input int ign_at);
    int          n = iters(b);
    logic [63:0] p = a * b;
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    step();
    start = 1'b0;
    op_a  = rnd64();
    op_b  = rnd64();
    for (int k = 1; k <= n; k++) begin
      check("busy_run", 64'(busy), 64'd1);
      check("done_run", 64'(done), 64'd0);
      check("res_held", result, exp_res);
      start = (k == ign_at);
      op_a  = rnd64();
      op_b  = rnd64();
      step();
    end
    start   = 1'b0;
    exp_res = p;
    check("done", 64'(done), 64'd1);
    check("busy_done", 64'(busy), 64'd0);
    check("result", result, p);
    check("zero", 64'(zero), 64'(p == 64'd0));
  endtask

  task automatic idle_step();
    step();
    check("done_idle", 64'(done), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
    check("res_idle", result, exp_res);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    flush   = 1'b0;
    op_a    = '0;
    op_b    = '0;
    exp_res = '0;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_zero", 64'(zero), 64'd1);
    rst_n = 1'b1;
    step();

    run_op(64'd6, 64'd7, 0);
    idle_step();
    run_op(64'd123, 64'd0, 0);
    idle_step();
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
    run_op(64'd3, 64'h8000_0000_0000_0000, 10);
    idle_step();

    // flush mid-run: no done, result held
    start = 1'b1;
    op_a  = 64'd5;
    op_b  = 64'hFF;
    step();
    start = 1'b0;
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_res", result, exp_res);
    for (int k = 0; k < 10; k++) begin
      check("flush_nodone", 64'(done), 64'd0);
      step();
    end
    run_op(64'd2, 64'd9, 0);
    idle_step();

    // asynchronous reset between edges mid-run
    start = 1'b1;
    op_a  = 64'd5;
    op_b  = 64'hFF;
    step();
    start = 1'b0;
    step();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_result", result, 64'd0);
    check("arst_zero", 64'(zero), 64'd1);
    exp_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_op(64'd4, 64'd4, 0);
    idle_step();

    for (int r = 0; r < 30; r++) begin
      logic [63:0] a;
      logic [63:0] b;
      a = rnd64();
      b = rnd64() >> $urandom_range(0, 64);
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(32, 64);
      run_op(a, b, 0);
      if ($urandom_range(0, 1) == 1) idle_step();
    end
    idle_step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
